// File: rtl/accel_dot_unit.sv
// accel_dot_unit: lane-serial signed dot product (DOT / DOT_ACC / DOT_RELU); optional saturation via ACCEL_DOT_SAT_EN
module accel_dot_unit #(
  parameter int ELEM_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] acc_in,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result
);
  localparam int LANES = 32 / ELEM_W;
  localparam logic [1:0] LAST = 2'(LANES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [31:0] a_r, b_r;
  logic [1:0] lane;
  logic relu;
  logic signed [31:0] acc, prod32, step;
  logic signed [ELEM_W-1:0] ea, eb;
  logic signed [2*ELEM_W-1:0] prod;
  logic signed [32:0] sum;
  // lane 0 always sits in the low bits; operands shift down one lane per cycle
  always_comb begin
    ea = a_r[ELEM_W-1:0];
    eb = b_r[ELEM_W-1:0];
    prod = ea * eb;
    prod32 = 32'(prod);
    sum = 33'(acc) + 33'(prod32);
`ifdef ACCEL_DOT_SAT_EN
    step = (sum[32] != sum[31]) ? (sum[32] ? 32'sh80000000 : 32'sh7FFFFFFF) : sum[31:0];
`else
    step = sum[31:0];
`endif
  end
  // control FSM, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      result_valid <= 1'b0;
      result <= '0;
      acc <= '0;
      a_r <= '0;
      b_r <= '0;
      lane <= '0;
      relu <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state != RUN && start) begin
        state <= RUN;
        busy <= 1'b1;
        a_r <= src_a;
        b_r <= src_b;
        acc <= (op == 2'b01) ? acc_in : '0;
        relu <= op == 2'b10;
        lane <= '0;
      end else if (state == RUN) begin
        a_r <= a_r >> ELEM_W;
        b_r <= b_r >> ELEM_W;
        acc <= step;
        lane <= lane + 2'd1;
        if (lane == LAST) begin
          state <= DONE;
          busy <= 1'b0;
          result_valid <= 1'b1;
          result <= (relu && step[31]) ? '0 : step;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_accel_dot_unit.sv
// tb_accel_dot_unit: randomized and directed checks of accel_dot_unit against an arithmetic reference model
module tb_accel_dot_unit;
  localparam int ELEM_W = 8;
  localparam int LANES = 32 / ELEM_W;
  logic clk, reset, start, busy, result_valid;
  logic [1:0] op;
  logic [31:0] src_a, src_b, acc_in, result;
  int checks = 0;
  int errors = 0;

  accel_dot_unit #(.ELEM_W(ELEM_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .acc_in(acc_in), .busy(busy), .result_valid(result_valid), .result(result)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    longint s;
    longint p;
    s = (o == 2'b01) ? longint'($signed(c)) : 0;
    for (int i = 0; i < LANES; i++) begin
      p = longint'($signed(a[i*ELEM_W +: ELEM_W])) * longint'($signed(b[i*ELEM_W +: ELEM_W]));
      s = s + p;
`ifdef ACCEL_DOT_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
      s = longint'($signed(s[31:0]));
`endif
    end
    if (o == 2'b10 && s < 0) s = 0;
    return s[31:0];
  endfunction

  task automatic scramble();
    op = 2'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    acc_in = $urandom;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] e, input string nm);
    start = 1; op = o; src_a = a; src_b = b; acc_in = c;
    @(posedge clk); #1;
    start = 0;
    scramble();
    for (int k = 0; k <= LANES; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if (k < LANES && (busy !== 1'b1 || result_valid !== 1'b0)) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b valid=%b, required busy=1 valid=0", nm, k, busy, result_valid);
      end
      if (k == LANES && (busy !== 1'b0 || result_valid !== 1'b1 || result !== e)) begin
        errors++;
        $display("FAIL %s done: busy=%b valid=%b result=%h, required busy=0 valid=1 result=%h", nm, busy, result_valid, result, e);
      end
    end
  endtask

  task automatic idle_check(input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== e) begin
      errors++;
      $display("FAIL %s idle: busy=%b valid=%b result=%h, required 0 0 %h", nm, busy, result_valid, result, e);
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 1; op = 0; src_a = 32'h01020304; src_b = 32'h01010101; acc_in = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b result=%h, required 0 0 0", busy, result_valid, result);
    end
    reset = 0; start = 0;
    idle_check(32'h0, "reset_release");
  endtask

  task automatic test_directed();
    run(2'b00, 32'h01020304, 32'h01010101, 32'h0, 32'd10, "dot");
    idle_check(32'd10, "dot_hold");
    run(2'b10, 32'hFFFFFFFF, 32'h01010101, 32'h0, 32'h0, "relu_neg");
    idle_check(32'h0, "relu_hold");
    run(2'b00, 32'hFFFFFFFF, 32'h01010101, 32'h0, 32'hFFFFFFFC, "dot_neg");
    idle_check(32'hFFFFFFFC, "dot_neg_hold");
    run(2'b01, 32'h01020304, 32'h01010101, 32'd100, 32'd110, "dot_acc");
    idle_check(32'd110, "dot_acc_hold");
    run(2'b11, 32'h01020304, 32'h01010101, 32'd100, 32'd10, "reserved_op");
    idle_check(32'd10, "reserved_hold");
`ifdef ACCEL_DOT_SAT_EN
    run(2'b01, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFF0, 32'h7FFFFFFF, "acc_overflow");
`else
    run(2'b01, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFF0, 32'h8000FBF4, "acc_overflow");
`endif
    idle_check(result, "overflow_hold_state");
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [31:0] a, b, c;
    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom); a = $urandom; b = $urandom; c = $urandom;
      if (n % 4 == 0) begin a = 32'h80808080; b = (n % 8 == 0) ? 32'h80808080 : 32'h7F7F7F7F; end
      run(o, a, b, c, model(o, a, b, c), "random");
      if (n % 3 == 0) idle_check(model(o, a, b, c), "random_hold");
    end
  endtask

  task automatic test_ignore_start();
    start = 1; op = 2'b00; src_a = 32'h01020304; src_b = 32'h01010101; acc_in = 0;
    @(posedge clk); #1;
    start = 1; op = 2'b01; src_a = $urandom; src_b = $urandom; acc_in = $urandom;
    for (int k = 1; k <= LANES; k++) begin
      @(posedge clk); #1;
      if (k == LANES - 1) start = 0;
      checks++;
      if (k < LANES && busy !== 1'b1) begin
        errors++;
        $display("FAIL ignore_start busy cycle %0d: busy=%b, required 1", k, busy);
      end
      if (k == LANES && (result_valid !== 1'b1 || result !== 32'd10)) begin
        errors++;
        $display("FAIL ignore_start done: valid=%b result=%h, required 1 0000000a", result_valid, result);
      end
    end
    idle_check(32'd10, "ignore_start_after");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    run(2'b00, 32'h01020304, 32'h01010101, 32'h0, 32'd10, "b2b_first");
    run(2'b01, a, b, c, model(2'b01, a, b, c), "b2b_second");
    run(2'b10, 32'hFFFFFFFF, 32'h01010101, 32'h0, 32'h0, "b2b_third");
    idle_check(32'h0, "b2b_end");
  endtask

  task automatic test_reset_abort();
    run(2'b00, 32'h01020304, 32'h01010101, 32'h0, 32'd10, "pre_abort");
    @(posedge clk); #1;
    start = 1; op = 2'b01; src_a = 32'h01020304; src_b = 32'h01010101; acc_in = 32'd100;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL abort: busy=%b valid=%b result=%h, required 0 0 0", busy, result_valid, result);
    end
    for (int k = 0; k < 6; k++) idle_check(32'h0, "abort_quiet");
    run(2'b01, 32'h01020304, 32'h01010101, 32'd100, 32'd110, "after_abort");
  endtask

  initial begin
    start = 0; reset = 0; op = 0; src_a = 0; src_b = 0; acc_in = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
